// File: rtl/mel_energy_acc.sv
// Mel filterbank energy accumulator.
// Squares each FFT bin, splits the bin power between two adjacent triangular
// mel bands using the filter-ROM weight, accumulates 64-bit saturating band
// energies over a frame, then drains the bands in order on a valid/ready port.
module mel_energy_acc #(
  parameter int NBANDS = 26,
  parameter int BAND_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [15:0]       in_re,
  input  logic signed [15:0]       in_im,
  input  logic [BAND_W-1:0]        in_band,
  input  logic [15:0]              in_w,
  input  logic                     in_last,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [BAND_W-1:0]        o_band,
  output logic [63:0]              o_data
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 64;
  localparam int SQ_W   = 2*DATA_W - 1;   // 31-bit unsigned square
  localparam int PWR_W  = 2*DATA_W;       // 32-bit power, max 2^31
  localparam int PRD_W  = PWR_W + COEF_W; // 48-bit weighted product
  localparam int PART_W = PRD_W - 15;     // 33-bit weighted share

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  // Saturating accumulate: the log stage must never see a wrapped energy.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PART_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W+1-PART_W){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  // Floor of 1 so the downstream natural log never receives zero.
  function automatic logic [ACC_W-1:0] floor_one(input logic [ACC_W-1:0] a);
    return (a == '0) ? {{(ACC_W-1){1'b0}}, 1'b1} : a;
  endfunction

  logic [0:0]        state;
  logic [BAND_W-1:0] ptr;
  logic              accept;
  logic              drain_hs;

  logic signed [2*DATA_W-1:0] re_sq_c;
  logic signed [2*DATA_W-1:0] im_sq_c;

  logic              vld_p1;
  logic [SQ_W-1:0]   sq_re_p1;
  logic [SQ_W-1:0]   sq_im_p1;
  logic [BAND_W-1:0] band_p1;
  logic [COEF_W-1:0] w_p1;
  logic              last_p1;

  logic              vld_p2;
  logic [PWR_W-1:0]  pwr_p2;
  logic [BAND_W-1:0] band_p2;
  logic [COEF_W-1:0] w_p2;
  logic              last_p2;

  logic [COEF_W-1:0] w_lo_c;
  logic [PRD_W-1:0]  prod_hi_c;
  logic [PRD_W-1:0]  prod_lo_c;

  logic              vld_p3;
  logic [PART_W-1:0] p_hi_p3;
  logic [PART_W-1:0] p_lo_p3;
  logic [BAND_W-1:0] band_p3;
  logic              last_p3;

  logic              last_done_p4;

  logic [ACC_W-1:0]  acc [NBANDS];
  logic [ACC_W-1:0]  acc_sel;

  assign accept   = in_valid && in_ready;
  assign drain_hs = (state == DRAIN) && o_ready;

  assign re_sq_c = in_re * in_re;
  assign im_sq_c = in_im * in_im;

  // ---- stage p1: squares of the accepted bin ----
  // Valid bits of the pipeline are the only reset state in the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      vld_p3       <= 1'b0;
      last_done_p4 <= 1'b0;
    end else begin
      vld_p1       <= accept;
      vld_p2       <= vld_p1;
      vld_p3       <= vld_p2;
      last_done_p4 <= vld_p3 && last_p3;
    end
  end

  // Square both components; the sign bit of a square is always zero.
  always_ff @(posedge clk) begin
    sq_re_p1 <= re_sq_c[SQ_W-1:0];
    sq_im_p1 <= im_sq_c[SQ_W-1:0];
    band_p1  <= in_band;
    w_p1     <= in_w;
    last_p1  <= in_last;
  end

  // ---- stage p2: bin power ----
  // Sum of squares; 32 bits hold the (-32768,-32768) worst case of 2^31.
  always_ff @(posedge clk) begin
    pwr_p2  <= {1'b0, sq_re_p1} + {1'b0, sq_im_p1};
    band_p2 <= band_p1;
    w_p2    <= w_p1;
    last_p2 <= last_p1;
  end

  // The falling-slope weight is the complement of the rising one in Q1.15.
  assign w_lo_c    = 16'h8000 - w_p2;
  assign prod_hi_c = {{COEF_W{1'b0}}, pwr_p2} * {{PWR_W{1'b0}}, w_p2};
  assign prod_lo_c = {{COEF_W{1'b0}}, pwr_p2} * {{PWR_W{1'b0}}, w_lo_c};

  // ---- stage p3: weighted shares for band b and band b-1 ----
  // Q1.15 scaling by truncation (drop the 15 fraction bits).
  always_ff @(posedge clk) begin
    p_hi_p3 <= prod_hi_c[PRD_W-1:15];
    p_lo_p3 <= prod_lo_c[PRD_W-1:15];
    band_p3 <= band_p2;
    last_p3 <= last_p2;
  end

  // ---- stage p4: accumulate ----
  // Each band register either clears on its drain handshake or absorbs the
  // share addressed to it; b and b-1 are distinct, so two bands update at
  // once. A rising share for b==NBANDS and a falling share for b==0 match no
  // register and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBANDS; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < NBANDS; i++) begin
        if (drain_hs && (ptr == BAND_W'(i))) begin
          acc[i] <= '0;
        end else if (vld_p3) begin
          if (band_p3 == BAND_W'(i))
            acc[i] <= sat_add(acc[i], p_hi_p3);
          else if (band_p3 == BAND_W'(i + 1))
            acc[i] <= sat_add(acc[i], p_lo_p3);
        end
      end
    end
  end

  // Frame control: close input after the last bin, drain once it has been
  // accumulated, reopen input after the final band handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      in_ready <= 1'b1;
      ptr      <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept && in_last) in_ready <= 1'b0;
          if (last_done_p4) begin
            state <= DRAIN;
            ptr   <= '0;
          end
        end
        DRAIN: begin
          if (o_ready) begin
            if (ptr == BAND_W'(NBANDS - 1)) begin
              ptr      <= '0;
              state    <= ACCUM;
              in_ready <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
          ptr      <= '0;
        end
      endcase
    end
  end

  // Select the band being drained without an out-of-range array index.
  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NBANDS; i++) begin
      if (ptr == BAND_W'(i)) acc_sel = acc[i];
    end
  end

  assign o_valid = (state == DRAIN);
  assign o_band  = ptr;
  assign o_data  = o_valid ? floor_one(acc_sel) : '0;

endmodule

// File: tb/tb_mel_energy_acc.sv
// Scoreboard bench for mel_energy_acc: a behavioural band model queues the
// expected drain sequence per frame; a monitor pops and compares on handshakes.
module tb_mel_energy_acc;

  localparam int NB = 26;
  localparam int BW = 6;
  localparam logic [63:0] MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  logic [BW-1:0]     in_band;
  logic [15:0]       in_w;
  logic              in_last;
  logic              o_valid;
  logic              o_ready;
  logic [BW-1:0]     o_band;
  logic [63:0]       o_data;

  mel_energy_acc #(.NBANDS(NB), .BAND_W(BW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_band(in_band), .in_w(in_w),
    .in_last(in_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_band(o_band), .o_data(o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          band;
    logic [63:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mdl [NB];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [63:0] mdl_sat(input logic [63:0] a,
                                          input logic [63:0] b);
    return (a > MAX64 - b) ? MAX64 : a + b;
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < NB; i++) mdl[i] = '0;
  endfunction

  function automatic void mdl_bin(input int re, input int im, input int band,
                                  input int w);
    logic [63:0] pwr, phi, plo;
    pwr = 64'(re * re) + 64'(im * im);
    phi = (pwr * 64'(w)) >> 15;
    plo = (pwr * 64'(32768 - w)) >> 15;
    if (band < NB) mdl[band] = mdl_sat(mdl[band], phi);
    if (band >= 1) mdl[band-1] = mdl_sat(mdl[band-1], plo);
  endfunction

  function automatic void push_frame();
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.band = i;
      e.data = (mdl[i] == 0) ? 64'd1 : mdl[i];
      sbq.push_back(e);
    end
    mdl_clear();
  endfunction

  // Drive one bin for one clock; the model only sees bins the DUT can accept.
  task automatic send_bin(input int re, input int im, input int band,
                          input int w, input bit last);
    in_re    = 16'(re);
    in_im    = 16'(im);
    in_band  = BW'(band);
    in_w     = 16'(w);
    in_last  = last;
    in_valid = 1'b1;
    if (in_ready) begin
      mdl_bin(re, im, band, w);
      if (last) push_frame();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((sbq.size() != 0 || o_valid || !in_ready) && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("frame drained within budget", 64'(c < 2000), 64'd1);
    check_val("scoreboard empty after frame", 64'(sbq.size()), 64'd0);
  endtask

  // Single-bin frame with latency and in_ready timing checks.
  task automatic frame_one();
    int cyc;
    bit rdy_seen;
    send_bin(3, 4, 2, 16384, 1'b1);
    cyc = 1;
    check_val("in_ready low after last accept", 64'(in_ready), 64'd0);
    while (!o_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("o_valid cycle after last accept", 64'(cyc), 64'd5);
    rdy_seen = 1'b0;
    cyc = 0;
    while (o_valid && cyc < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check_val("in_ready low throughout drain", 64'(rdy_seen), 64'd0);
    check_val("in_ready high right after drain", 64'(in_ready), 64'd1);
    wait_idle();
  endtask

  // Compare every delivered band against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      if (sbq.size() == 0) begin
        check_val("o_valid with nothing expected", 64'(o_valid), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check_val($sformatf("o_band k=%0d", e.band), 64'(o_band), 64'(e.band));
        check_val($sformatf("o_data band%0d", e.band), o_data, e.data);
      end
    end
  end

  initial begin
    int          c;
    int          hold;
    logic [63:0] held_d;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    in_band  = '0;
    in_w     = '0;
    in_last  = 1'b0;
    o_ready  = 1'b1;
    mdl_clear();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset in_ready", 64'(in_ready), 64'd1);
    check_val("reset o_valid", 64'(o_valid), 64'd0);
    check_val("reset o_band", 64'(o_band), 64'd0);
    check_val("reset o_data", o_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-bin frame: bands 1 and 2 each get 12, rest floor to 1.
    frame_one();

    // Edge bands: out-of-range halves dropped.
    send_bin(1, 0, 0, 32768, 1'b0);
    send_bin(-32768, -32768, 26, 0, 1'b1);
    wait_idle();

    // Back-to-back bins into the same band every cycle.
    for (int i = 1; i <= 100; i++) send_bin(1000, 0, 5, 32768, i == 100);
    wait_idle();

    // Backpressure at k=3 for 7 cycles, with ignored in_valid pulses.
    send_bin(100, -200, 7, 10000, 1'b0);
    send_bin(5, 5, 3, 20000, 1'b0);
    send_bin(-1234, 777, 12, 32768, 1'b1);
    c = 0;
    while (!o_valid && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    hold   = 0;
    held_d = '0;
    c      = 0;
    while (o_valid && c < 300) begin
      if (o_band == BW'(3) && hold < 7) begin
        if (hold == 0) held_d = o_data;
        else begin
          check_val("held o_band", 64'(o_band), 64'd3);
          check_val("held o_data", o_data, held_d);
        end
        o_ready = 1'b0;
        hold++;
      end else begin
        o_ready = 1'b1;
      end
      in_valid = (o_band < BW'(20)) && c[0];
      in_re    = 16'($urandom);
      in_im    = 16'($urandom);
      in_band  = BW'($urandom_range(0, NB));
      in_w     = 16'($urandom_range(0, 32768));
      in_last  = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    o_ready  = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_val("backpressure cycles applied", 64'(hold), 64'd7);
    wait_idle();

    // Saturation: band 0 preloaded near full scale, then one max bin.
    dut.acc[0] = MAX64 - 64'(1 << 30);
    mdl[0]     = MAX64 - 64'(1 << 30);
    send_bin(-32768, -32768, 0, 32768, 1'b1);
    wait_idle();

    // Reset in the middle of a drain, then a clean single-bin frame.
    send_bin(50, 60, 10, 8000, 1'b0);
    send_bin(7, -9, 11, 30000, 1'b1);
    c = 0;
    while (!(o_valid && o_band == BW'(10)) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("reached drain band 10", 64'(o_band), 64'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid-drain reset o_valid", 64'(o_valid), 64'd0);
    check_val("mid-drain reset in_ready", 64'(in_ready), 64'd1);
    check_val("mid-drain reset o_band", 64'(o_band), 64'd0);
    check_val("mid-drain reset o_data", o_data, 64'd0);
    rst = 1'b0;
    sbq.delete();
    mdl_clear();
    @(posedge clk); #1;
    frame_one();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
